// File: rtl/fp_multiply_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Exponent bias for a given exponent width.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  localparam int          FP_BIAS    = fp_bias(FP_EXP_W);
  localparam logic [63:0] FP_QNAN_SP = fp_qnan(FP_EXP_W, FP_MAN_W);

  // Operand class; denormals count as zero because they are flushed.
  function automatic fp_class_t fp_classify(input logic [63:0] w,
                                            input int exp_w, input int man_w);
    logic [63:0] e, f, emax;
    emax = (64'd1 << exp_w) - 64'd1;
    e    = (w >> man_w) & emax;
    f    = w & ((64'd1 << man_w) - 64'd1);
    if (e == 64'd0)       return FP_ZERO;
    else if (e == emax)   return (f == 64'd0) ? FP_INF : FP_NAN;
    else                  return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_multiply_pipe_if.sv
// Operand/result stream bundle for the FP multiplier.
interface fp_multiply_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inv;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, flag_ovf, flag_unf, flag_inv
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_multiply_pipe_round_rne.sv
// Normalise a mantissa product, round to nearest-even, adjust exponent.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]       i_prod,
  input  logic signed [EXP_W+1:0]  i_exp,
  output logic [MAN_W-1:0]         o_frac,
  output logic signed [EXP_W+1:0]  o_exp
);
  localparam int EW = EXP_W + 2;

  logic             w_msb;
  logic [MAN_W-1:0] w_frac;
  logic             w_g;
  logic             w_s;
  logic             w_inc;
  logic             w_cy;

  // Product lies in [1,4); when MSB is set the binary point moves one left.
  assign w_msb  = i_prod[2*MAN_W+1];
  assign w_frac = w_msb ? i_prod[2*MAN_W:MAN_W+1] : i_prod[2*MAN_W-1:MAN_W];
  assign w_g    = w_msb ? i_prod[MAN_W]           : i_prod[MAN_W-1];
  assign w_s    = w_msb ? |i_prod[MAN_W-1:0]      : |i_prod[MAN_W-2:0];
  assign w_inc  = w_g & (w_s | w_frac[0]);

  // A carry out of the fraction wraps it to zero and bumps the exponent.
  assign {w_cy, o_frac} = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
  assign o_exp = i_exp + EW'(w_msb) + EW'(w_cy);
endmodule

// File: rtl/fp_multiply_pipe.sv
// Three-stage IEEE-style FP multiplier with RNE rounding and backpressure.
module fp_multiply_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic          clk,
  input  logic          rst,
  fp_multiply_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int EW     = EXP_W + 2;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int STAGES = 3;

  localparam logic [W-1:0]         QNAN  = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS  = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  // Handshake: whole pipe moves together whenever the output slot frees up.
  logic              w_en;
  logic              w_acc;
  logic [STAGES:1]   r_vld_pipe;
  logic [STAGES:0]   w_vld_pipe;

  assign w_en       = !r_vld_pipe[STAGES] | bus.out_ready;
  assign w_acc      = bus.in_valid & w_en;
  assign w_vld_pipe = {r_vld_pipe, w_acc};
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld_pipe[STAGES];

  // Stage valid shift register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst)       r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= w_vld_pipe[STAGES-1:0];
  end

  // ---------------- S1: classify, sign, exponent sum, mantissa product
  fp_class_t             w1_ca, w1_cb;
  logic [MAN_W:0]        w1_ma, w1_mb;
  logic [PW-1:0]         w1_prod;
  logic signed [EW-1:0]  w1_e;

  assign w1_ca   = fp_classify(64'(bus.a), EXP_W, MAN_W);
  assign w1_cb   = fp_classify(64'(bus.b), EXP_W, MAN_W);
  assign w1_ma   = {1'b1, bus.a[MAN_W-1:0]};
  assign w1_mb   = {1'b1, bus.b[MAN_W-1:0]};
  assign w1_prod = {{(MAN_W+1){1'b0}}, w1_ma} * {{(MAN_W+1){1'b0}}, w1_mb};
  assign w1_e    = $signed({2'b00, bus.a[W-2:MAN_W]})
                 + $signed({2'b00, bus.b[W-2:MAN_W]}) - BIAS;

  fp_class_t             r1_ca, r1_cb;
  logic                  r1_s;
  logic signed [EW-1:0]  r1_e;
  logic [PW-1:0]         r1_prod;

  // S1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_ca <= FP_ZERO; r1_cb <= FP_ZERO; r1_s <= 1'b0;
      r1_e  <= '0;      r1_prod <= '0;
    end else if (w_en) begin
      r1_ca <= w1_ca; r1_cb <= w1_cb;
      r1_s  <= bus.a[W-1] ^ bus.b[W-1];
      r1_e  <= w1_e;  r1_prod <= w1_prod;
    end
  end

  // ---------------- S2: normalise and round
  logic [MAN_W-1:0]      w2_frac;
  logic signed [EW-1:0]  w2_e;

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rnd (
    .i_prod (r1_prod),
    .i_exp  (r1_e),
    .o_frac (w2_frac),
    .o_exp  (w2_e)
  );

  fp_class_t             r2_ca, r2_cb;
  logic                  r2_s;
  logic signed [EW-1:0]  r2_e;
  logic [MAN_W-1:0]      r2_frac;

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_ca <= FP_ZERO; r2_cb <= FP_ZERO; r2_s <= 1'b0;
      r2_e  <= '0;      r2_frac <= '0;
    end else if (w_en) begin
      r2_ca <= r1_ca; r2_cb <= r1_cb; r2_s <= r1_s;
      r2_e  <= w2_e;  r2_frac <= w2_frac;
    end
  end

  // ---------------- S3: special-case select
  logic         w3_nan, w3_inf, w3_zero;
  logic [W-1:0] w3_c;
  logic         w3_ovf, w3_unf, w3_inv;

  assign w3_nan  = (r2_ca == FP_NAN)  | (r2_cb == FP_NAN);
  assign w3_inf  = (r2_ca == FP_INF)  | (r2_cb == FP_INF);
  assign w3_zero = (r2_ca == FP_ZERO) | (r2_cb == FP_ZERO);

  // Result mux in priority order: invalid, Inf, zero, overflow, underflow, normal.
  always_comb begin
    w3_c   = {r2_s, r2_e[EXP_W-1:0], r2_frac};
    w3_ovf = 1'b0;
    w3_unf = 1'b0;
    w3_inv = 1'b0;
    if (w3_nan | (w3_inf & w3_zero)) begin
      w3_c   = QNAN;
      w3_inv = 1'b1;
    end else if (w3_inf) begin
      w3_c = {r2_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w3_zero) begin
      w3_c = {r2_s, {(W-1){1'b0}}};
    end else if (r2_e >= EMAX) begin
      w3_c   = {r2_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w3_ovf = 1'b1;
    end else if (r2_e <= EZERO) begin
      w3_c   = {r2_s, {(W-1){1'b0}}};
      w3_unf = 1'b1;
    end
  end

  logic [W-1:0] r3_c;
  logic         r3_ovf, r3_unf, r3_inv;

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r3_c <= '0; r3_ovf <= 1'b0; r3_unf <= 1'b0; r3_inv <= 1'b0;
    end else if (w_en) begin
      r3_c <= w3_c; r3_ovf <= w3_ovf; r3_unf <= w3_unf; r3_inv <= w3_inv;
    end
  end

  assign bus.c        = r3_c;
  assign bus.flag_ovf = r3_ovf;
  assign bus.flag_unf = r3_unf;
  assign bus.flag_inv = r3_inv;
endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Directed-vector bench for fp_multiply_pipe (single precision).
module tb_fp_multiply_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_multiply_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_multiply_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drives one operation with out_ready high; returns result, flags
  // {ovf,unf,inv} and the cycle index (accept cycle = 0) of out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c, output logic [2:0] fl,
                        output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    c  = bus.c;
    fl = {bus.flag_ovf, bus.flag_unf, bus.flag_inv};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.c !== 32'h0) begin n_fail++; $display("FAIL reset_c: got %h expected 00000000", bus.c); end
    n_checks++;
    if ({bus.flag_ovf, bus.flag_unf, bus.flag_inv} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.flag_ovf, bus.flag_unf, bus.flag_inv});
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_arith();
    logic [31:0] va [6] = '{32'h3FC00000, 32'h3F800001, 32'h3F800000, 32'h3FC00001, 32'h3F800001, 32'h3F800003};
    logic [31:0] vb [6] = '{32'h40000000, 32'h3F800001, 32'hBF800000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
    logic [31:0] vc [6] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h40100001, 32'h3FC00002, 32'h3FC00004};
    logic [31:0] c;
    logic [2:0]  fl;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], c, fl, lat);
      n_checks++;
      if (c !== vc[i]) begin n_fail++; $display("FAIL arith_c[%0d]: got %h expected %h", i, c, vc[i]); end
      n_checks++;
      if (fl !== 3'b000) begin n_fail++; $display("FAIL arith_flags[%0d]: got %b expected 000", i, fl); end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL arith_latency[%0d]: got %0d expected 3", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [8] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000,
                            32'h80000000, 32'h7FC00001, 32'h80800000, 32'h00000001};
    logic [31:0] vb [8] = '{32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000,
                            32'h3F800000, 32'h3F800000, 32'h00800000, 32'h3F800000};
    logic [31:0] vc [8] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                            32'h80000000, 32'h7FC00000, 32'h80000000, 32'h00000000};
    logic [2:0]  vf [8] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] c;
    logic [2:0]  fl;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], c, fl, lat);
      n_checks++;
      if (c !== vc[i]) begin n_fail++; $display("FAIL special_c[%0d]: got %h expected %h", i, c, vc[i]); end
      n_checks++;
      if (fl !== vf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, fl, vf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [6] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00001, 32'h3F800001, 32'h3F800003, 32'h40000000};
    logic [31:0] vb [6] = '{32'h40000000, 32'hBF800000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h40000000};
    logic [31:0] vc [6] = '{32'h40400000, 32'hBF800000, 32'h40100001, 32'h3FC00002, 32'h3FC00004, 32'h40800000};
    int          in_idx = 0, out_idx = 0, cyc = 0;
    bit          saw_stall = 1'b0, hold_pend = 1'b0, acc;
    logic [31:0] held_c = '0;
    while (out_idx < 6 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc <= 7);
      bus.in_valid  = (in_idx < 6);
      if (in_idx < 6) begin bus.a = va[in_idx]; bus.b = vb[in_idx]; end
      #1;
      if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      if (hold_pend) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.c !== held_c) begin
          n_fail++; $display("FAIL b2b_hold cyc %0d: got v=%b c=%h expected v=1 c=%h", cyc, bus.out_valid, bus.c, held_c);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (bus.c !== vc[out_idx]) begin
          n_fail++; $display("FAIL b2b_c[%0d]: got %h expected %h", out_idx, bus.c, vc[out_idx]);
        end
        out_idx++;
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      held_c    = bus.c;
      if (acc) in_idx++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_checks++;
    if (out_idx !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 6", out_idx); end
    n_checks++;
    if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_stall); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra: got out_valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] c;
    logic [2:0]  fl;
    int          lat;
    bit          seen = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.a = 32'h3FC00000; bus.b = 32'h40000000;
    @(negedge clk);
    bus.a = 32'h40000000; bus.b = 32'h40000000;
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_dropped: got emitted=%b expected 0", seen); end
    run_op(32'h40000000, 32'h40400000, c, fl, lat);
    n_checks++;
    if (c !== 32'h40C00000) begin n_fail++; $display("FAIL midrst_next_c: got %h expected 40C00000", c); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL midrst_next_latency: got %0d expected 3", lat); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
